// File: rtl/spi_master_sequencer_pkg.sv
// Shared definitions for the SPI master sequencer: FSM encoding and default sizing.
package spi_master_sequencer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DELIVER   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/spi_master_sequencer_fifo.sv
// Synchronous TX FIFO with a combinational head and an occupancy count.
module spi_sync_fifo
  import spi_master_sequencer_pkg::*;
#(
  parameter int Data_width = DEFAULT_DATA_WIDTH,
  parameter int Fifo_depth = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [Data_width-1:0]       push_data,
  input  logic                        pop,
  output logic [Data_width-1:0]       head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(Fifo_depth):0] count
);

  localparam int PTR_W = $clog2(Fifo_depth);

  logic [Data_width-1:0] mem [Fifo_depth];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (PTR_W + 1)'(Fifo_depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_master_sequencer.sv
// Feeds queued TX words to an SPI master one at a time and hands each reply to a consumer.
module spi_master_sequencer
  import spi_master_sequencer_pkg::*;
#(
  parameter int Data_width     = DEFAULT_DATA_WIDTH,
  parameter int Fifo_depth     = DEFAULT_FIFO_DEPTH,
  parameter int Start_hold     = 4,
  parameter int Timeout_cycles = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [Data_width-1:0]       i_tx_data,
  input  logic                        i_tx_valid,
  output logic                        o_tx_ready,
  output logic [Data_width-1:0]       o_spi_data,
  output logic                        o_spi_start,
  input  logic                        i_spi_done,
  input  logic [Data_width-1:0]       i_spi_rx,
  output logic [Data_width-1:0]       o_rx_data,
  output logic                        o_rx_valid,
  input  logic                        i_rx_ready,
  output logic                        o_busy,
  output logic                        o_error,
  output logic [$clog2(Fifo_depth):0] o_count
);

  localparam int HOLD_W = $clog2(Start_hold + 1);
  localparam int TMO_W  = $clog2(Timeout_cycles + 1);

  seq_state_t            state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  done_q;
  logic                  done_rise;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  tx_push;
  logic [Data_width-1:0] fifo_head;

  assign o_tx_ready = !fifo_full;
  assign tx_push    = i_tx_valid && o_tx_ready;
  assign fifo_pop   = (state == ST_LOAD) && !fifo_empty;
  assign done_rise  = i_spi_done && !done_q;

  spi_sync_fifo #(
    .Data_width (Data_width),
    .Fifo_depth (Fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (i_tx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      done_q      <= 1'b0;
      o_spi_start <= 1'b0;
      o_rx_valid  <= 1'b0;
      o_error     <= 1'b0;
      o_busy      <= 1'b0;
      o_spi_data  <= '0;
      o_rx_data   <= '0;
    end else begin
      // done_q tracks the level in every state so a level already high on WAIT_DONE entry is not an edge.
      done_q  <= i_spi_done;
      o_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (o_count != '0) begin
            state  <= ST_LOAD;
            o_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          o_spi_data  <= fifo_head;
          hold_cnt    <= '0;
          o_spi_start <= 1'b1;
          state       <= ST_START;
        end
        ST_START: begin
          if (hold_cnt == HOLD_W'(Start_hold - 1)) begin
            o_spi_start <= 1'b0;
            tmo_cnt     <= '0;
            state       <= ST_WAIT_DONE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (done_rise) begin
            o_rx_data  <= i_spi_rx;
            o_rx_valid <= 1'b1;
            state      <= ST_DELIVER;
          end else if (tmo_cnt == TMO_W'(Timeout_cycles - 1)) begin
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DELIVER: begin
          if (i_rx_ready) begin
            o_rx_valid <= 1'b0;
            if (o_count != '0) begin
              state <= ST_LOAD;
            end else begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed and randomized bench for spi_master_sequencer with a queue-based reference model.
module tb_spi_master_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       o_tx_ready;
  logic [7:0] o_spi_data;
  logic       o_spi_start;
  logic       i_spi_done = 1'b0;
  logic [7:0] i_spi_rx = 8'h00;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_ready = 1'b0;
  logic       o_busy;
  logic       o_error;
  logic [2:0] o_count;

  int total = 0;
  int bad   = 0;

  // Words accepted by the FIFO and not yet handed to the SPI master, oldest first.
  logic [7:0] model_q [$];
  logic [7:0] burst [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  spi_master_sequencer #(
    .Data_width     (8),
    .Fifo_depth     (4),
    .Start_hold     (4),
    .Timeout_cycles (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tx_data   (i_tx_data),
    .i_tx_valid  (i_tx_valid),
    .o_tx_ready  (o_tx_ready),
    .o_spi_data  (o_spi_data),
    .o_spi_start (o_spi_start),
    .i_spi_done  (i_spi_done),
    .i_spi_rx    (i_spi_rx),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .i_rx_ready  (i_rx_ready),
    .o_busy      (o_busy),
    .o_error     (o_error),
    .o_count     (o_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no finish required=finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    chk_bit("tx_ready_before_push", o_tx_ready, 1'b1);
    i_tx_valid = 1'b1;
    i_tx_data  = w;
    tick();
    i_tx_valid = 1'b0;
    model_q.push_back(w);
  endtask

  // Runs one transfer up to the point where the reply is presented to the consumer.
  task automatic xfer(input logic [7:0] rx_word, input int delay, input bit chk_hold, input bit pre_high);
    int k;
    logic [7:0] exp_tx;
    k = 0;
    while (o_spi_start !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk_bit("start_seen", o_spi_start, 1'b1);
    exp_tx = (model_q.size() > 0) ? model_q.pop_front() : 8'hxx;
    chk_val("spi_data", 32'(o_spi_data), 32'(exp_tx));
    if (pre_high) i_spi_done = 1'b1;
    k = 0;
    while (o_spi_start === 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (chk_hold) chk_val("start_hold_cycles", k, 4);
    chk_val("spi_data_stable", 32'(o_spi_data), 32'(exp_tx));
    chk_bit("busy_in_wait", o_busy, 1'b1);
    if (pre_high) begin
      repeat (3) begin
        tick();
        chk_bit("done_high_ignored", o_rx_valid, 1'b0);
      end
      i_spi_done = 1'b0;
      tick();
    end
    repeat (delay) begin
      chk_bit("no_early_rx_valid", o_rx_valid, 1'b0);
      tick();
    end
    i_spi_done = 1'b1;
    i_spi_rx   = rx_word;
    tick();
    chk_bit("rx_valid_set", o_rx_valid, 1'b1);
    chk_val("rx_data", 32'(o_rx_data), 32'(rx_word));
    i_spi_done = 1'b0;
    i_spi_rx   = ~rx_word;
  endtask

  task automatic deliver_ack(input logic [7:0] exp_rx, input int wait_cycles);
    repeat (wait_cycles) begin
      chk_bit("rx_valid_held", o_rx_valid, 1'b1);
      chk_val("rx_data_held", 32'(o_rx_data), 32'(exp_rx));
      chk_bit("no_start_in_deliver", o_spi_start, 1'b0);
      tick();
    end
    chk_bit("rx_valid_at_ack", o_rx_valid, 1'b1);
    i_rx_ready = 1'b1;
    tick();
    i_rx_ready = 1'b0;
    chk_bit("rx_valid_cleared", o_rx_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] r2;
    logic [7:0] exp_w;
    int k;

    // Reset state
    tick();
    tick();
    chk_val("rst_count", 32'(o_count), 0);
    chk_bit("rst_busy", o_busy, 1'b0);
    chk_bit("rst_start", o_spi_start, 1'b0);
    chk_bit("rst_rx_valid", o_rx_valid, 1'b0);
    chk_bit("rst_error", o_error, 1'b0);
    chk_val("rst_spi_data", 32'(o_spi_data), 0);
    chk_val("rst_rx_data", 32'(o_rx_data), 0);
    rst = 1'b0;
    tick();
    chk_bit("ready_after_rst", o_tx_ready, 1'b1);

    // Single word with start latency of three cycles
    push_word(8'hA5);
    chk_bit("lat_idle_start", o_spi_start, 1'b0);
    chk_bit("lat_idle_busy", o_busy, 1'b0);
    chk_val("lat_count", 32'(o_count), 1);
    tick();
    chk_bit("lat_load_start", o_spi_start, 1'b0);
    chk_bit("lat_load_busy", o_busy, 1'b1);
    tick();
    chk_bit("lat_start_high", o_spi_start, 1'b1);
    xfer(8'h3C, 2, 1'b1, 1'b0);
    deliver_ack(8'h3C, 2);
    tick();
    chk_bit("single_idle", o_busy, 1'b0);

    // Done already high when WAIT_DONE is entered
    r = 8'($urandom);
    r2 = 8'($urandom);
    push_word(r);
    xfer(r2, 1, 1'b1, 1'b1);
    deliver_ack(r2, 0);

    // Randomized pairs of words
    for (int i = 0; i < 4; i++) begin
      push_word(8'($urandom));
      push_word(8'($urandom));
      for (int j = 0; j < 2; j++) begin
        r = 8'($urandom);
        xfer(r, $urandom_range(0, 4), 1'b1, 1'b0);
        deliver_ack(r, $urandom_range(0, 3));
      end
    end
    tick();
    chk_bit("rand_idle", o_busy, 1'b0);
    chk_val("rand_empty", 32'(o_count), 0);

    // Burst into a full FIFO while the consumer stalls
    push_word(8'($urandom));
    r = 8'($urandom);
    xfer(r, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push_word(burst[i]);
      chk_val("burst_count", 32'(o_count), i + 1);
    end
    chk_bit("full_not_ready", o_tx_ready, 1'b0);
    i_tx_valid = 1'b1;
    i_tx_data  = 8'h55;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_bit("bp_ready", o_tx_ready, 1'b0);
      chk_val("bp_count", 32'(o_count), 4);
      chk_bit("bp_rx_valid", o_rx_valid, 1'b1);
      chk_val("bp_rx_data", 32'(o_rx_data), 32'(r));
      chk_bit("bp_no_start", o_spi_start, 1'b0);
    end
    i_rx_ready = 1'b1;
    tick();
    i_rx_ready = 1'b0;
    chk_bit("bp_rx_valid_clear", o_rx_valid, 1'b0);
    chk_bit("bp_load_busy", o_busy, 1'b1);
    chk_val("bp_load_count", 32'(o_count), 4);
    tick();
    chk_val("full_load_push_rejected", 32'(o_count), 3);
    chk_bit("burst_first_start", o_spi_start, 1'b1);
    chk_bit("ready_after_pop", o_tx_ready, 1'b1);
    tick();
    i_tx_valid = 1'b0;
    model_q.push_back(8'h55);
    chk_val("held_word_accepted", 32'(o_count), 4);
    r = 8'($urandom);
    xfer(r, 0, 1'b0, 1'b0);
    deliver_ack(r, 1);
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      xfer(r, $urandom_range(0, 3), 1'b1, 1'b0);
      deliver_ack(r, 0);
    end
    chk_val("burst_model_drained", model_q.size(), 0);
    tick();
    chk_bit("burst_idle", o_busy, 1'b0);

    // Timeout when the slave never answers; the queued word still goes out afterwards
    push_word(8'($urandom));
    push_word(8'($urandom));
    k = 0;
    while (o_spi_start !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk_bit("tmo_start", o_spi_start, 1'b1);
    exp_w = model_q.pop_front();
    chk_val("tmo_spi_data", 32'(o_spi_data), 32'(exp_w));
    k = 0;
    while (o_spi_start === 1'b1 && k < 20) begin
      tick();
      k++;
    end
    k = 0;
    while (o_error !== 1'b1 && k < 1100) begin
      tick();
      k++;
    end
    chk_val("tmo_latency", k, 1024);
    chk_bit("tmo_idle", o_busy, 1'b0);
    chk_val("tmo_fifo_kept", 32'(o_count), 1);
    chk_bit("tmo_no_rx_valid", o_rx_valid, 1'b0);
    tick();
    chk_bit("tmo_error_pulse", o_error, 1'b0);
    r = 8'($urandom);
    xfer(r, 1, 1'b1, 1'b0);
    deliver_ack(r, 0);

    // Push/pop in the same LOAD cycle, then reset during WAIT_DONE
    tick();
    push_word(8'($urandom));
    chk_val("pp_count1", 32'(o_count), 1);
    chk_bit("pp_idle", o_busy, 1'b0);
    push_word(8'($urandom));
    chk_val("pp_count2", 32'(o_count), 2);
    chk_bit("pp_load_busy", o_busy, 1'b1);
    chk_bit("pp_load_start", o_spi_start, 1'b0);
    push_word(8'($urandom));
    chk_val("pp_push_pop_count", 32'(o_count), 2);
    chk_bit("pp_start", o_spi_start, 1'b1);
    exp_w = model_q.pop_front();
    chk_val("pp_spi_data", 32'(o_spi_data), 32'(exp_w));
    k = 0;
    while (o_spi_start === 1'b1 && k < 20) begin
      tick();
      k++;
    end
    tick();
    chk_val("mid_count", 32'(o_count), 2);
    chk_bit("mid_busy", o_busy, 1'b1);
    rst = 1'b1;
    tick();
    model_q.delete();
    chk_val("mid_rst_count", 32'(o_count), 0);
    chk_bit("mid_rst_busy", o_busy, 1'b0);
    chk_bit("mid_rst_start", o_spi_start, 1'b0);
    chk_bit("mid_rst_error", o_error, 1'b0);
    chk_val("mid_rst_spi_data", 32'(o_spi_data), 0);
    rst = 1'b0;
    tick();
    chk_bit("mid_ready_after_rst", o_tx_ready, 1'b1);
    repeat (3) begin
      tick();
      chk_bit("post_rst_no_error", o_error, 1'b0);
      chk_bit("post_rst_idle", o_busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
